// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank: op encodings, sequencer states
// and the JK next-state rule used by every cell.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_APPLY  = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with clock enable and asynchronous active-low clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // Cell state: only moves when the bank sequencer commits to this cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (en_i) begin
      q_q <= jk_next(q_q, j_i, k_i);
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a JK flip-flop bank between two requesters; each
// granted op runs APPLY then COMMIT, and completion is reported by done/err.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int N_FLOPS = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid_i,
  input  logic [IDX_W-1:0]   req0_idx_i,
  input  logic [1:0]         req0_op_i,
  output logic               req0_ready_o,
  input  logic               req1_valid_i,
  input  logic [IDX_W-1:0]   req1_idx_i,
  input  logic [1:0]         req1_op_i,
  output logic               req1_ready_o,
  output logic [N_FLOPS-1:0] q_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               done_id_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         op_q, op_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               done_id_q, done_id_d;

  logic               grant_any_s;
  logic               grant_id_s;
  logic               oor_s;
  logic               drive_s;
  logic [N_FLOPS-1:0] en_s;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_any_s = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_id_s = ~last_q;
    end else if (req1_valid_i) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  assign req0_ready_o = (state_q == ST_IDLE) && grant_any_s && !grant_id_s;
  assign req1_ready_o = (state_q == ST_IDLE) && grant_any_s &&  grant_id_s;

  assign oor_s   = (32'(idx_q) >= N_FLOPS);
  assign drive_s = (state_q != ST_IDLE);

  // Sequencer next state, request latch and completion reporting.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    idx_d     = idx_q;
    op_d      = op_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d = ST_APPLY;
          last_d  = grant_id_s;
          id_d    = grant_id_s;
          idx_d   = grant_id_s ? req1_idx_i : req0_idx_i;
          op_d    = grant_id_s ? req1_op_i  : req0_op_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        err_d     = oor_s;
        done_id_d = id_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and status registers; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      idx_q     <= '0;
      op_q      <= JK_HOLD;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      done_q    <= done_d;
      err_q     <= err_d;
      done_id_q <= done_id_d;
    end
  end

  // An out-of-range index matches no cell, so the bank is left untouched.
  for (genvar i = 0; i < N_FLOPS; i++) begin : g_cell
    assign en_s[i] = (state_q == ST_COMMIT) && (32'(idx_q) == i);
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en_s[i]),
      .j_i   (drive_s & op_q[1]),
      .k_i   (drive_s & op_q[0]),
      .q_o   (q_o[i])
    );
  end

  assign busy_o    = drive_s;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign err_o     = err_q;

endmodule
